// File: rtl/router_nport.sv
// Store-and-forward packet router: buffers one packet from a valid/ready input
// stream, then forwards it to one output port (unicast) or all ports (broadcast).
module router_nport #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_dest_addr,
  input  logic [1:0]           in_packet_type,
  input  logic [DATA_W-1:0]    in_payload,
  input  logic                 in_eop,
  output logic [NUM_PORTS-1:0] out_valid,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic [DATA_W-1:0]    out_payload,
  output logic                 out_eop,
  output logic                 err_overflow,
  output logic                 err_bad_dest
);

  // Handshake: a beat moves on a port only in a cycle where both valid and
  // ready are high; valid and data hold steady until that cycle.

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECEIVE = 3'd1;
  localparam logic [2:0] ST_DROP    = 3'd2;
  localparam logic [2:0] ST_FINISH  = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;

  logic [2:0]           state;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [ADDR_W-1:0]    dest;
  logic [1:0]           ptype;
  logic                 ovf;
  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 accept_in;
  logic                 new_fwd;
  logic                 is_bcast;
  logic [NUM_PORTS-1:0] onehot;
  logic                 out_fire;

  assign accept_in = in_valid & in_ready;
  assign is_bcast  = (ptype == 2'b01);
  // A new packet is forwarded only if it is not a discard and its port exists.
  assign new_fwd   = !in_packet_type[1] && (int'(in_dest_addr) < NUM_PORTS);

  always_comb begin
    onehot       = '0;
    out_valid    = '0;
    out_payload  = '0;
    out_eop      = 1'b0;
    out_fire     = 1'b0;
    in_ready     = 1'b0;
    err_overflow = 1'b0;
    err_bad_dest = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      onehot[p] = (int'(dest) == p);
    end
    in_ready = reset && (state == ST_IDLE || state == ST_RECEIVE || state == ST_DROP);
    if (state == ST_SEND) begin
      out_valid   = is_bcast ? {NUM_PORTS{1'b1}} : onehot;
      out_payload = mem[rd_ptr[IW-1:0]];
      out_eop     = (rd_ptr == wr_ptr - PW'(1));
      // Broadcast waits for every consumer so all ports see the same beat.
      out_fire    = is_bcast ? (&out_ready) : (|(onehot & out_ready));
    end
    if (state == ST_FINISH) begin
      err_overflow = ovf;
      err_bad_dest = !ptype[1] && (int'(dest) >= NUM_PORTS);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dest   <= '0;
      ptype  <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_in) begin
            dest   <= in_dest_addr;
            ptype  <= in_packet_type;
            wr_ptr <= PW'(1);
            if (in_eop) state <= new_fwd ? ST_SEND : ST_FINISH;
            else        state <= new_fwd ? ST_RECEIVE : ST_DROP;
          end
        end
        ST_RECEIVE: begin
          if (accept_in) begin
            if (wr_ptr == DEPTH_P) begin
              ovf   <= 1'b1;
              state <= in_eop ? ST_FINISH : ST_DROP;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
              if (in_eop) state <= ST_SEND;
            end
          end
        end
        ST_DROP: begin
          if (accept_in && in_eop) state <= ST_FINISH;
        end
        ST_FINISH: begin
          ovf    <= 1'b0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          state  <= ST_IDLE;
        end
        ST_SEND: begin
          if (out_fire) begin
            if (out_eop) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              state  <= ST_IDLE;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Packet storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (accept_in && state == ST_IDLE) begin
      mem[0] <= in_payload;
    end else if (accept_in && state == ST_RECEIVE && wr_ptr < DEPTH_P) begin
      mem[wr_ptr[IW-1:0]] <= in_payload;
    end
  end

endmodule

// File: tb/tb_router_nport.sv
// Self-checking bench for router_nport: a 4-port and a 3-port instance share
// the input stream; a packet-level model predicts forwarded beats and errors.
module tb_router_nport;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sel3 = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        in_dest_addr = '0;
  logic [1:0]        in_packet_type = '0;
  logic [DATA_W-1:0] in_payload = '0;
  logic              in_eop = 1'b0;
  logic [3:0]        out_ready = 4'hF;

  logic              in_valid4, in_valid3, in_ready4, in_ready3;
  logic [3:0]        out_valid4;
  logic [2:0]        out_valid3;
  logic [DATA_W-1:0] out_payload4, out_payload3;
  logic              out_eop4, out_eop3, err_ovf4, err_ovf3, err_bad4, err_bad3;

  logic              obs_in_ready, obs_eop, obs_ovf, obs_bad;
  logic [3:0]        obs_valid;
  logic [DATA_W-1:0] obs_payload;

  // {eop, payload} of every beat the model expects to leave the router
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] beats[$];
  logic [3:0]        ready_q[$];
  bit                rand_ready = 1'b0;
  int                total = 0;
  int                bad = 0;

  assign in_valid4 = in_valid & ~sel3;
  assign in_valid3 = in_valid & sel3;

  router_nport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_PORTS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_dest_addr(in_dest_addr), .in_packet_type(in_packet_type),
    .in_payload(in_payload), .in_eop(in_eop), .out_valid(out_valid4),
    .out_ready(out_ready), .out_payload(out_payload4), .out_eop(out_eop4),
    .err_overflow(err_ovf4), .err_bad_dest(err_bad4)
  );

  router_nport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_PORTS(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_dest_addr(in_dest_addr), .in_packet_type(in_packet_type),
    .in_payload(in_payload), .in_eop(in_eop), .out_valid(out_valid3),
    .out_ready(out_ready[2:0]), .out_payload(out_payload3), .out_eop(out_eop3),
    .err_overflow(err_ovf3), .err_bad_dest(err_bad3)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs_in_ready = sel3 ? in_ready3 : in_ready4;
    obs_valid    = sel3 ? {1'b0, out_valid3} : out_valid4;
    obs_payload  = sel3 ? out_payload3 : out_payload4;
    obs_eop      = sel3 ? out_eop3 : out_eop4;
    obs_ovf      = sel3 ? err_ovf3 : err_ovf4;
    obs_bad      = sel3 ? err_bad3 : err_bad4;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives the packet held in 'beats', then checks the outcome the model predicts.
  task automatic send_pkt(input logic [1:0] d, input logic [1:0] t);
    int         n, np, waitc, c;
    logic [3:0] all, mask, rdy;
    bit         fwd, exp_ovf, exp_bad, fire, stalled;
    logic [DATA_W-1:0] pp;
    logic       pe;
    n   = beats.size();
    np  = sel3 ? 3 : 4;
    all = sel3 ? 4'b0111 : 4'b1111;
    fwd = 1'b0; exp_ovf = 1'b0; exp_bad = 1'b0;
    if (t[1])              fwd = 1'b0;
    else if (int'(d) >= np) exp_bad = 1'b1;
    else if (n > DEPTH)    exp_ovf = 1'b1;
    else                   fwd = 1'b1;
    mask = (t == 2'b01) ? all : (4'b0001 << d);
    if (fwd) for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), beats[i]});

    for (int i = 0; i < n; i++) begin
      in_valid       = 1'b1;
      in_dest_addr   = (i == 0) ? d : 2'($urandom);
      in_packet_type = (i == 0) ? t : 2'($urandom);
      in_payload     = beats[i];
      in_eop         = (i == n - 1);
      waitc = 0;
      @(negedge clk);
      while (!obs_in_ready && waitc < 50) begin
        @(negedge clk);
        waitc++;
      end
      chk("in_ready_wait", 32'(waitc < 50), 1);
      chk("valid_during_rx", obs_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_eop   = 1'b0;
    beats.delete();

    if (fwd) begin
      c = 0; stalled = 1'b0; pp = '0; pe = 1'b0;
      while (exp_q.size() > 0 && c < 300) begin
        if (ready_q.size() > 0) rdy = ready_q.pop_front();
        else if (rand_ready && $urandom_range(0, 3) == 0) rdy = 4'($urandom);
        else rdy = 4'hF;
        out_ready = rdy;
        @(negedge clk);
        chk("out_valid", obs_valid, mask);
        chk("in_ready_send", obs_in_ready, 0);
        chk("err_send", {obs_ovf, obs_bad}, 0);
        if (stalled) begin
          chk("hold_payload", obs_payload, pp);
          chk("hold_eop", obs_eop, pe);
        end
        fire = (t == 2'b01) ? ((rdy & all) == all) : rdy[d];
        if (fire) begin
          chk("payload", obs_payload, exp_q[0][DATA_W-1:0]);
          chk("eop", obs_eop, exp_q[0][DATA_W]);
          void'(exp_q.pop_front());
        end
        stalled = !fire;
        pp = obs_payload;
        pe = obs_eop;
        @(posedge clk); #1;
        c++;
      end
      chk("send_drained", exp_q.size(), 0);
      exp_q.delete();
      out_ready = 4'hF;
      @(negedge clk);
      chk("in_ready_after", obs_in_ready, 1);
      chk("valid_after", obs_valid, 0);
    end else begin
      @(negedge clk);
      chk("err_overflow", obs_ovf, exp_ovf);
      chk("err_bad_dest", obs_bad, exp_bad);
      chk("no_output", obs_valid, 0);
      chk("finish_ready", obs_in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_pulse_end", {obs_ovf, obs_bad}, 0);
      chk("ready_after_drop", obs_in_ready, 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n, r;
    logic [1:0] d, t;

    // reset values on both instances
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready4", in_ready4, 0);
    chk("rst_in_ready3", in_ready3, 0);
    chk("rst_out_valid", {out_valid4, out_valid3}, 0);
    chk("rst_eop_err", {out_eop4, err_ovf4, err_bad4, out_eop3, err_ovf3, err_bad3}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {in_ready4, in_ready3}, 2'b11);

    // directed unicast to port 2
    beats = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd2, 2'b00);

    // broadcast stalled by one consumer for three cycles
    beats = '{8'hA5, 8'h5A};
    ready_q = '{4'b1011, 4'b1011, 4'b1011};
    send_pkt(2'd0, 2'b01);

    // exactly DEPTH beats, then one beat too many, then a normal packet
    for (int i = 0; i < DEPTH; i++) beats.push_back(DATA_W'($urandom));
    send_pkt(2'd3, 2'b00);
    for (int i = 0; i < DEPTH + 1; i++) beats.push_back(DATA_W'($urandom));
    send_pkt(2'd1, 2'b00);
    beats = '{8'hC3, 8'h3C};
    send_pkt(2'd1, 2'b00);

    // 3-port instance: nonexistent port, then a discard
    sel3 = 1'b1;
    beats = '{8'h01, 8'h02};
    send_pkt(2'd3, 2'b00);
    beats = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_pkt(2'd1, 2'b10);
    beats = '{8'h66};
    send_pkt(2'd2, 2'b00);
    sel3 = 1'b0;

    // reset in the middle of a packet
    in_valid = 1'b1; in_dest_addr = 2'd1; in_packet_type = 2'b00;
    in_payload = 8'h01; in_eop = 1'b0;
    @(posedge clk); #1;
    in_payload = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready4, 0);
    chk("midrst_outputs", {out_valid4, out_eop4, err_ovf4, err_bad4}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_release", in_ready4, 1);
    @(posedge clk); #1;
    beats = '{8'h7E};
    send_pkt(2'd0, 2'b00);

    // randomized traffic with random consumer back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      sel3 = (k % 4 == 3);
      n = $urandom_range(1, DEPTH + 2);
      r = $urandom_range(0, 9);
      t = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
      d = 2'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) beats.push_back(DATA_W'($urandom));
      send_pkt(d, t);
    end
    sel3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
